// File: rtl/datapath_pkg.sv
// Shared datapath types for the store buffer: default widths, fence FSM states
// and the store entry layout.
package datapath_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    FENCE = 1'b1
  } sb_state_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match selector: finds the most recently pushed valid entry whose
// address equals the load address.
module sb_fwd_match
  import datapath_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic [PW-1:0]     head_i,
  input  logic [PW-1:0]     tail_i,
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [ADDR_W-1:0] addr_i [DEPTH],
  input  logic [DATA_W-1:0] data_i [DEPTH],
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic [PW-1:0] span;
  logic [PW-1:0] idx;
  logic          in_win;

  // Walk oldest to youngest so a later match overrides an earlier one.
  // A zero span with valid entries means the FIFO is full.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    span   = tail_i - head_i;
    idx    = head_i;
    in_win = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx    = head_i + PW'(k);
      in_win = (span == '0) || (PW'(k) < span);
      if (in_win && valid_i[idx] && (addr_i[idx] == ld_addr_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer ahead of data memory: drains one store per granted cycle,
// forwards buffered data to loads and blocks stores during a fence.
module store_buffer
  import datapath_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [DATA_W-1:0] ld_data,
  input  logic              drain_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              fence_req,
  output logic              fence_busy,
  output logic [CW-1:0]     count
);

  sb_state_t         state_q, state_d;
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              push, pop, empty;

  assign empty      = (count_q == '0);
  assign st_ready   = (count_q != CW'(DEPTH)) && (state_q == IDLE);
  assign push       = st_valid && st_ready;
  assign mem_we     = !empty && drain_en;
  assign pop        = mem_we;
  assign mem_addr   = empty ? '0 : addr_q[head_q];
  assign mem_data   = empty ? '0 : data_q[head_q];
  assign fence_busy = (state_q == FENCE);
  assign count      = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fence_req && !empty) state_d = FENCE;
      FENCE:   if (pop && (count_q == CW'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (pop) begin
        head_q          <= head_q + PW'(1);
        valid_q[head_q] <= 1'b0;
      end
      if (push) begin
        tail_q          <= tail_q + PW'(1);
        valid_q[tail_q] <= 1'b1;
      end
    end
  end

  // Payload needs no reset: every read of it is qualified by count or valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fwd (
    .head_i   (head_q),
    .tail_i   (tail_q),
    .valid_i  (valid_q),
    .addr_i   (addr_q),
    .data_i   (data_q),
    .ld_addr_i(ld_addr),
    .hit_o    (ld_hit),
    .data_o   (ld_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [31:0] ld_addr, ld_data;
  logic        ld_hit;
  logic        drain_en, mem_we;
  logic [31:0] mem_addr, mem_data;
  logic        fence_req, fence_busy;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .drain_en(drain_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .fence_req(fence_req), .fence_busy(fence_busy), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending stores in FIFO order plus a fence-busy flag.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  ent_t        popped;
  logic        mbusy = 1'b0;
  logic        e_ready, e_we, e_hit;
  logic [31:0] e_maddr, e_mdata, e_ldata;
  int          sz;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_st_ready", st_ready, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_data, 0);
      chk("rst_ld_hit", ld_hit, 0);
      chk("rst_ld_data", ld_data, 0);
      chk("rst_fence_busy", fence_busy, 0);
      chk("rst_count", count, 0);
      q.delete();
      mbusy = 1'b0;
    end else begin
      sz      = q.size();
      e_ready = (sz < DEPTH) && !mbusy;
      e_we    = (sz != 0) && drain_en;
      e_maddr = (sz != 0) ? q[0].a : 32'h0;
      e_mdata = (sz != 0) ? q[0].d : 32'h0;
      e_hit   = 1'b0;
      e_ldata = 32'h0;
      for (int i = 0; i < sz; i++)
        if (q[i].a == ld_addr) begin
          e_hit   = 1'b1;
          e_ldata = q[i].d;
        end
      chk("st_ready", st_ready, e_ready);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_maddr);
      chk("mem_data", mem_data, e_mdata);
      chk("ld_hit", ld_hit, e_hit);
      chk("ld_data", ld_data, e_ldata);
      chk("fence_busy", fence_busy, mbusy);
      chk("count", count, sz);
      if (mem_we && count == 0) begin
        errors++;
        $display("FAIL write_while_empty: mem_we=1 with count=0 at %0t", $time);
      end
      if (st_valid && st_ready && count == DEPTH) begin
        errors++;
        $display("FAIL push_while_full: accepted with count=%0d at %0t", count, $time);
      end
      if (e_we) popped = q.pop_front();
      if (st_valid && e_ready) q.push_back('{st_addr, st_data});
      if (mbusy) mbusy = (q.size() != 0);
      else       mbusy = fence_req && (sz != 0);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; st_valid = 0; st_addr = 0; st_data = 0;
    ld_addr = 0; drain_en = 0; fence_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single store, held then drained
    mid();
    chk("t1_ready_after_rst", st_ready, 1);
    chk("t1_count_after_rst", count, 0);
    nxt();
    st_valid = 1; st_addr = 32'h10; st_data = 32'hDEADBEEF;
    nxt();
    st_valid = 0;
    mid();
    chk("t1_count1", count, 1);
    chk("t1_no_we", mem_we, 0);
    nxt();
    drain_en = 1;
    mid();
    chk("t1_we", mem_we, 1);
    chk("t1_waddr", mem_addr, 32'h10);
    chk("t1_wdata", mem_data, 32'hDEADBEEF);
    nxt();
    mid();
    chk("t1_count0", count, 0);
    chk("t1_we_off", mem_we, 0);
    nxt();
    drain_en = 0;

    // 2: fill to full, reject fifth, drain in order
    for (int i = 0; i < 4; i++) begin
      st_valid = 1; st_addr = 32'(4 * i); st_data = 32'h100 + 32'(i);
      nxt();
    end
    st_addr = 32'h50; st_data = 32'h555;
    mid();
    chk("t2_full_count", count, 4);
    chk("t2_full_ready", st_ready, 0);
    nxt();
    st_valid = 0;
    mid();
    chk("t2_fifth_rejected", count, 4);
    nxt();
    drain_en = 1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("t2_drain_we", mem_we, 1);
      chk("t2_drain_addr", mem_addr, 32'(4 * i));
      chk("t2_drain_data", mem_data, 32'h100 + 32'(i));
      nxt();
    end
    drain_en = 0;
    mid();
    chk("t2_empty", count, 0);
    nxt();

    // 3: duplicate addresses, youngest forwards
    st_valid = 1; st_addr = 32'h20; st_data = 32'h11;
    nxt();
    st_data = 32'h22;
    nxt();
    st_valid = 0; ld_addr = 32'h20;
    mid();
    chk("t3_hit", ld_hit, 1);
    chk("t3_youngest", ld_data, 32'h22);
    nxt();
    ld_addr = 32'h24;
    mid();
    chk("t3_miss_hit", ld_hit, 0);
    chk("t3_miss_data", ld_data, 0);
    nxt();

    // 4: fence with two pending stores, then fence on empty
    fence_req = 1;
    mid();
    chk("t4_busy_pre", fence_busy, 0);
    nxt();
    fence_req = 0; drain_en = 1; st_valid = 1; st_addr = 32'h99; st_data = 32'h99;
    mid();
    chk("t4_busy_a", fence_busy, 1);
    chk("t4_ready_a", st_ready, 0);
    chk("t4_count_a", count, 2);
    nxt();
    mid();
    chk("t4_busy_b", fence_busy, 1);
    chk("t4_ready_b", st_ready, 0);
    chk("t4_count_b", count, 1);
    nxt();
    st_valid = 0;
    mid();
    chk("t4_busy_done", fence_busy, 0);
    chk("t4_count_done", count, 0);
    nxt();
    fence_req = 1;
    nxt();
    fence_req = 0;
    mid();
    chk("t4_empty_fence", fence_busy, 0);
    nxt();
    drain_en = 0;

    // 5: hold occupancy 3 with paired push/drain across pointer wrap
    for (int i = 0; i < 3; i++) begin
      st_valid = 1; st_addr = 32'h30 + 32'(4 * i); st_data = (32'h30 + 32'(4 * i)) ^ 32'hA5A50000;
      nxt();
    end
    drain_en = 1;
    for (int i = 0; i < 10; i++) begin
      st_addr = 32'h40 + 32'(4 * i); st_data = (32'h40 + 32'(4 * i)) ^ 32'hA5A50000;
      mid();
      chk("t5_count3", count, 3);
      chk("t5_pair_we", mem_we, 1);
      chk("t5_order_addr", mem_addr, (i < 3) ? 32'h30 + 32'(4 * i) : 32'h40 + 32'(4 * (i - 3)));
      chk("t5_order_data", mem_data,
          ((i < 3) ? 32'h30 + 32'(4 * i) : 32'h40 + 32'(4 * (i - 3))) ^ 32'hA5A50000);
      nxt();
    end
    st_valid = 0; drain_en = 0;
    mid();
    chk("t5_count_end", count, 3);
    nxt();

    // 6: asynchronous reset in the middle of a drain cycle
    drain_en = 1; ld_addr = 32'h64;
    #1;
    chk("t6_we_before", mem_we, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_we_async", mem_we, 0);
    chk("t6_count_async", count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t6_no_stale_we", mem_we, 0);
      chk("t6_no_stale_hit", ld_hit, 0);
      nxt();
    end
    drain_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
